// File: rtl/calc_entry_ctrl.sv
// calc_entry_ctrl
// ---------------
// Keypad-entry sequencer for the two-operand calculator. Turns a stream of
// key codes into operand digit registers, a one-hot operator select and a
// phase code for the downstream digit mux and math datapath.
//
// Sequence: enter operand A -> pick operator -> enter operand B -> ENTER
// shows the result -> a new digit starts over (CLEAR works from anywhere).
//
// Optional feature macro: CALC_TIMEOUT_EN (idle auto-clear after
// TIMEOUT_CYCLES clocks without a key event). Left undefined, timeout_clr
// is tied low and the registers hold indefinitely.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   key_valid    level, high while a key is held (synchronous to clk)
//   key_code     0-9 digit, 10 ADD, 11 SUB, 12 MUL, 13 DIV, 14 ENTER, 15 CLEAR
//   num_state    phase code (also the FSM state register, for debug/checkers)
//                000 A_ENTRY, 001 OP_SEL, 010 B_ENTRY, 011 RESULT
//   tens_mem_1, ones_mem_1   operand A digits (0-9)
//   tens_mem_2, ones_mem_2   operand B digits (0-9)
//   arithmetic   one-hot operator: bit0 add, bit1 sub, bit2 mul, bit3 div
//   key_err      one-cycle pulse: accepted key edge ignored by current state
//   timeout_clr  one-cycle pulse on idle auto-clear
//
// Handshake: there is no ready. A key is a level on key_valid; its rising
// edge (key_valid & ~key_d) is the one event per press, and key_code is
// sampled on that edge only. key_valid must drop for at least one clock
// between presses or the second press is not seen.

module calc_entry_ctrl #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd500_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [2:0] num_state,
  output logic [4:0] tens_mem_1,
  output logic [4:0] ones_mem_1,
  output logic [4:0] tens_mem_2,
  output logic [4:0] ones_mem_2,
  output logic [4:0] arithmetic,
  output logic       key_err,
  output logic       timeout_clr
);

  typedef enum logic [2:0] {
    A_ENTRY = 3'b000,
    OP_SEL  = 3'b001,
    B_ENTRY = 3'b010,
    RESULT  = 3'b011
  } state_t;

  state_t     state;
  logic       key_d;
  logic [1:0] cnt_a;
  logic [1:0] cnt_b;

  logic       key_event;
  logic       is_digit;
  logic       is_op;
  logic       is_clear;
  logic [4:0] op_onehot;
  logic [4:0] digit;
  logic       state_ok;
  logic       timeout_fire;
  logic       clear_now;

  assign num_state = state;
  assign key_event = key_valid & ~key_d;

  always_comb begin
    is_digit  = (key_code <= 4'd9);
    is_op     = (key_code >= 4'd10) && (key_code <= 4'd13);
    is_clear  = (key_code == 4'd15);
    digit     = {1'b0, key_code};
    op_onehot = 5'b00000;
    case (key_code)
      4'd10:   op_onehot = 5'b00001;
      4'd11:   op_onehot = 5'b00010;
      4'd12:   op_onehot = 5'b00100;
      4'd13:   op_onehot = 5'b01000;
      default: op_onehot = 5'b00000;
    endcase
    state_ok  = (state == A_ENTRY) || (state == OP_SEL) ||
                (state == B_ENTRY) || (state == RESULT);
    // An illegal state register clears on the next clock regardless of keys.
    clear_now = ~state_ok | (key_event & is_clear) | timeout_fire;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= A_ENTRY;
      key_d      <= 1'b0;
      cnt_a      <= 2'd0;
      cnt_b      <= 2'd0;
      tens_mem_1 <= 5'd0;
      ones_mem_1 <= 5'd0;
      tens_mem_2 <= 5'd0;
      ones_mem_2 <= 5'd0;
      arithmetic <= 5'b00000;
      key_err    <= 1'b0;
    end else begin
      key_d   <= key_valid;
      key_err <= 1'b0;
      if (clear_now) begin
        state      <= A_ENTRY;
        cnt_a      <= 2'd0;
        cnt_b      <= 2'd0;
        tens_mem_1 <= 5'd0;
        ones_mem_1 <= 5'd0;
        tens_mem_2 <= 5'd0;
        ones_mem_2 <= 5'd0;
        arithmetic <= 5'b00000;
      end else if (key_event) begin
        case (state)
          A_ENTRY: begin
            if (is_digit) begin
              if (cnt_a == 2'd2) begin
                key_err <= 1'b1;
              end else begin
                tens_mem_1 <= ones_mem_1;
                ones_mem_1 <= digit;
                cnt_a      <= cnt_a + 2'd1;
              end
            end else if (is_op) begin
              arithmetic <= op_onehot;
              state      <= OP_SEL;
            end else begin
              key_err <= 1'b1;
            end
          end
          OP_SEL: begin
            if (is_digit) begin
              // First B digit: B starts from 00, so tens stays 0.
              tens_mem_2 <= 5'd0;
              ones_mem_2 <= digit;
              cnt_b      <= 2'd1;
              state      <= B_ENTRY;
            end else if (is_op) begin
              arithmetic <= op_onehot;
            end else begin
              key_err <= 1'b1;
            end
          end
          B_ENTRY: begin
            if (is_digit) begin
              if (cnt_b == 2'd2) begin
                key_err <= 1'b1;
              end else begin
                tens_mem_2 <= ones_mem_2;
                ones_mem_2 <= digit;
                cnt_b      <= cnt_b + 2'd1;
              end
            end else if (is_op) begin
              key_err <= 1'b1;
            end else begin
              state <= RESULT;
            end
          end
          RESULT: begin
            if (is_digit) begin
              // A digit after a result starts a fresh calculation with it.
              tens_mem_1 <= 5'd0;
              ones_mem_1 <= digit;
              cnt_a      <= 2'd1;
              tens_mem_2 <= 5'd0;
              ones_mem_2 <= 5'd0;
              cnt_b      <= 2'd0;
              arithmetic <= 5'b00000;
              state      <= A_ENTRY;
            end else begin
              key_err <= 1'b1;
            end
          end
          default: state <= A_ENTRY;
        endcase
      end
    end
  end

`ifdef CALC_TIMEOUT_EN
  logic [31:0] idle_cnt;

  // A key event in the expiry cycle wins; a blank A_ENTRY never times out.
  assign timeout_fire = ~key_event &&
                        (idle_cnt == TIMEOUT_CYCLES - 32'd1) &&
                        !((state == A_ENTRY) && (cnt_a == 2'd0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt    <= 32'd0;
      timeout_clr <= 1'b0;
    end else begin
      timeout_clr <= timeout_fire;
      if (key_event) begin
        idle_cnt <= 32'd0;
      end else begin
        idle_cnt <= idle_cnt + 32'd1;
      end
    end
  end
`else
  logic unused_timeout;

  assign timeout_fire   = 1'b0;
  assign timeout_clr    = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Self-checking bench for calc_entry_ctrl. A small reference model of the
// keypad sequencer predicts the full output vector for each clock after a
// key press; predictions go into exp_q and are popped when the DUT output
// is sampled (#1 after the rising edge).

module tb_calc_entry_ctrl;

  localparam int VW = 30;

`ifdef CALC_TIMEOUT_EN
  localparam int HOLD_CYCLES = 12;
`else
  localparam int HOLD_CYCLES = 20;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_valid;
  logic [3:0] key_code;
  logic [2:0] num_state;
  logic [4:0] tens_mem_1, ones_mem_1, tens_mem_2, ones_mem_2, arithmetic;
  logic       key_err;
  logic       timeout_clr;

  always #5 clk = ~clk;

  calc_entry_ctrl #(.TIMEOUT_CYCLES(32'd16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .num_state  (num_state),
    .tens_mem_1 (tens_mem_1),
    .ones_mem_1 (ones_mem_1),
    .tens_mem_2 (tens_mem_2),
    .ones_mem_2 (ones_mem_2),
    .arithmetic (arithmetic),
    .key_err    (key_err),
    .timeout_clr(timeout_clr)
  );

  // ---------------- scoreboard state ----------------
  logic [VW-1:0] exp_q[$];
  int            total_cnt = 0;
  int            pass_cnt  = 0;

  // reference model
  logic [2:0] m_state;
  logic [4:0] m_at, m_ao, m_bt, m_bo, m_op;
  int         m_ca, m_cb;
  logic       m_err;

  function automatic logic [VW-1:0] dut_vec();
    return {num_state, tens_mem_1, ones_mem_1, tens_mem_2, ones_mem_2,
            arithmetic, key_err, timeout_clr};
  endfunction

  function automatic logic [VW-1:0] model_vec(input logic err, input logic tclr);
    return {m_state, m_at, m_ao, m_bt, m_bo, m_op, err, tclr};
  endfunction

  task automatic model_clear();
    m_state = 3'b000;
    m_at = 5'd0; m_ao = 5'd0; m_bt = 5'd0; m_bo = 5'd0;
    m_op = 5'b00000;
    m_ca = 0; m_cb = 0;
  endtask

  task automatic model_key(input logic [3:0] c);
    m_err = 1'b0;
    if (c == 4'd15) begin
      model_clear();
    end else begin
      case (m_state)
        3'b000: begin
          if (c <= 4'd9) begin
            if (m_ca >= 2) m_err = 1'b1;
            else begin m_at = m_ao; m_ao = {1'b0, c}; m_ca++; end
          end else if (c <= 4'd13) begin
            m_op = 5'b00001 << (c - 4'd10);
            m_state = 3'b001;
          end else m_err = 1'b1;
        end
        3'b001: begin
          if (c <= 4'd9) begin
            m_bt = 5'd0; m_bo = {1'b0, c}; m_cb = 1; m_state = 3'b010;
          end else if (c <= 4'd13) m_op = 5'b00001 << (c - 4'd10);
          else m_err = 1'b1;
        end
        3'b010: begin
          if (c <= 4'd9) begin
            if (m_cb >= 2) m_err = 1'b1;
            else begin m_bt = m_bo; m_bo = {1'b0, c}; m_cb++; end
          end else if (c <= 4'd13) m_err = 1'b1;
          else m_state = 3'b011;
        end
        default: begin
          if (c <= 4'd9) begin
            model_clear();
            m_ao = {1'b0, c}; m_ca = 1;
          end else m_err = 1'b1;
        end
      endcase
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    @(negedge clk);
    key_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  // One press: key high for one clock, low for one clock. Pushes the
  // prediction for each of the two sampled clocks.
  task automatic press(input logic [3:0] c, output logic [VW-1:0] got_hit,
                       output logic [VW-1:0] got_rel);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = c;
    model_key(c);
    exp_q.push_back(model_vec(m_err, 1'b0));
    @(posedge clk); #1;
    got_hit = dut_vec();
    @(negedge clk);
    key_valid = 1'b0;
    exp_q.push_back(model_vec(1'b0, 1'b0));
    @(posedge clk); #1;
    got_rel = dut_vec();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [VW-1:0] e, g;
    rst_n = 1'b0; key_valid = 1'b0; key_code = 4'd0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back(model_vec(1'b0, 1'b0));
    e = exp_q.pop_front(); g = dut_vec(); total_cnt++;
    if (g !== e) $display("FAIL reset_values: got %h expected %h", g, e);
    else pass_cnt++;
    // Key held across reset release is an event on the first clock.
    @(negedge clk); key_valid = 1'b1; key_code = 4'd5;
    @(negedge clk); rst_n = 1'b1;
    model_key(4'd5);
    exp_q.push_back(model_vec(m_err, 1'b0));
    @(posedge clk); #1;
    e = exp_q.pop_front(); g = dut_vec(); total_cnt++;
    if (g !== e) $display("FAIL held_across_reset: got %h expected %h", g, e);
    else pass_cnt++;
    @(negedge clk); key_valid = 1'b0;
  endtask

  task automatic test_basic_sequence();
    logic [3:0] seq[$];
    logic [VW-1:0] e, g1, g2;
    apply_reset();
    seq = '{4'd4, 4'd7, 4'd10, 4'd1, 4'd2, 4'd14};
    foreach (seq[i]) begin
      press(seq[i], g1, g2);
      e = exp_q.pop_front(); total_cnt++;
      if (g1 !== e) $display("FAIL basic_key%0d: got %h expected %h", i, g1, e);
      else pass_cnt++;
      e = exp_q.pop_front(); total_cnt++;
      if (g2 !== e) $display("FAIL basic_idle%0d: got %h expected %h", i, g2, e);
      else pass_cnt++;
    end
    total_cnt++;
    if ({num_state, tens_mem_1, ones_mem_1, tens_mem_2, ones_mem_2, arithmetic} !==
        {3'b011, 5'd4, 5'd7, 5'd1, 5'd2, 5'b00001})
      $display("FAIL basic_final: got st=%b A=%0d/%0d B=%0d/%0d op=%b expected st=011 A=4/7 B=1/2 op=00001",
               num_state, tens_mem_1, ones_mem_1, tens_mem_2, ones_mem_2, arithmetic);
    else pass_cnt++;
  endtask

  task automatic test_third_digit();
    logic [3:0] seq[$];
    logic [VW-1:0] e, g1, g2;
    apply_reset();
    seq = '{4'd1, 4'd2, 4'd3};
    foreach (seq[i]) begin
      press(seq[i], g1, g2);
      e = exp_q.pop_front(); total_cnt++;
      if (g1 !== e) $display("FAIL third_key%0d: got %h expected %h", i, g1, e);
      else pass_cnt++;
      e = exp_q.pop_front(); total_cnt++;
      if (g2 !== e) $display("FAIL third_idle%0d: got %h expected %h", i, g2, e);
      else pass_cnt++;
    end
    total_cnt++;
    if ({tens_mem_1, ones_mem_1} !== {5'd1, 5'd2})
      $display("FAIL third_digit_value: got %0d/%0d expected 1/2", tens_mem_1, ones_mem_1);
    else pass_cnt++;
  endtask

  task automatic test_held_key();
    logic [VW-1:0] e, g;
    apply_reset();
    @(negedge clk);
    key_valid = 1'b1; key_code = 4'd5;
    model_key(4'd5);
    exp_q.push_back(model_vec(m_err, 1'b0));
    for (int i = 0; i < HOLD_CYCLES; i++) begin
      if (i > 0) exp_q.push_back(model_vec(1'b0, 1'b0));
      @(posedge clk); #1;
      e = exp_q.pop_front(); g = dut_vec(); total_cnt++;
      if (g !== e) $display("FAIL held_cycle%0d: got %h expected %h", i, g, e);
      else pass_cnt++;
    end
    @(negedge clk); key_valid = 1'b0;
    total_cnt++;
    if ({tens_mem_1, ones_mem_1} !== {5'd0, 5'd5})
      $display("FAIL held_value: got %0d/%0d expected 0/5", tens_mem_1, ones_mem_1);
    else pass_cnt++;
  endtask

  task automatic test_op_replace_restart();
    logic [3:0] seq[$];
    logic [VW-1:0] e, g1, g2;
    apply_reset();
    seq = '{4'd9, 4'd12, 4'd11};
    foreach (seq[i]) begin
      press(seq[i], g1, g2);
      e = exp_q.pop_front(); total_cnt++;
      if (g1 !== e) $display("FAIL opsel_key%0d: got %h expected %h", i, g1, e);
      else pass_cnt++;
      e = exp_q.pop_front(); total_cnt++;
      if (g2 !== e) $display("FAIL opsel_idle%0d: got %h expected %h", i, g2, e);
      else pass_cnt++;
    end
    total_cnt++;
    if (arithmetic !== 5'b00010)
      $display("FAIL op_replaced: got %b expected 00010", arithmetic);
    else pass_cnt++;
    seq = '{4'd3, 4'd14, 4'd6};
    foreach (seq[i]) begin
      press(seq[i], g1, g2);
      e = exp_q.pop_front(); total_cnt++;
      if (g1 !== e) $display("FAIL restart_key%0d: got %h expected %h", i, g1, e);
      else pass_cnt++;
      e = exp_q.pop_front(); total_cnt++;
      if (g2 !== e) $display("FAIL restart_idle%0d: got %h expected %h", i, g2, e);
      else pass_cnt++;
    end
    total_cnt++;
    if ({num_state, tens_mem_1, ones_mem_1, tens_mem_2, ones_mem_2, arithmetic} !==
        {3'b000, 5'd0, 5'd6, 5'd0, 5'd0, 5'b00000})
      $display("FAIL restart_final: got st=%b A=%0d/%0d B=%0d/%0d op=%b expected st=000 A=0/6 B=0/0 op=00000",
               num_state, tens_mem_1, ones_mem_1, tens_mem_2, ones_mem_2, arithmetic);
    else pass_cnt++;
  endtask

  task automatic test_clear_mid_b();
    logic [3:0] seq[$];
    logic [VW-1:0] e, g1, g2;
    apply_reset();
    seq = '{4'd5, 4'd10, 4'd8, 4'd15};
    foreach (seq[i]) begin
      press(seq[i], g1, g2);
      e = exp_q.pop_front(); total_cnt++;
      if (g1 !== e) $display("FAIL clear_key%0d: got %h expected %h", i, g1, e);
      else pass_cnt++;
      e = exp_q.pop_front(); total_cnt++;
      if (g2 !== e) $display("FAIL clear_idle%0d: got %h expected %h", i, g2, e);
      else pass_cnt++;
    end
    total_cnt++;
    if (dut_vec() !== {VW{1'b0}})
      $display("FAIL clear_all_zero: got %h expected %h", dut_vec(), {VW{1'b0}});
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    logic [VW-1:0] e, g, g1, g2;
    apply_reset();
    press(4'd1, g1, g2);
    e = exp_q.pop_front(); total_cnt++;
    if (g1 !== e) $display("FAIL async_pre_key: got %h expected %h", g1, e);
    else pass_cnt++;
    e = exp_q.pop_front(); total_cnt++;
    if (g2 !== e) $display("FAIL async_pre_idle: got %h expected %h", g2, e);
    else pass_cnt++;
    press(4'd12, g1, g2);
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    @(posedge clk); #3;
    rst_n = 1'b0;
    model_clear();
    exp_q.push_back(model_vec(1'b0, 1'b0));
    #1;
    e = exp_q.pop_front(); g = dut_vec(); total_cnt++;
    if (g !== e) $display("FAIL async_reset: got %h expected %h", g, e);
    else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_timeout();
    logic [VW-1:0] e, g, g1, g2;
    int pulses;
    apply_reset();
    press(4'd3, g1, g2);
    e = exp_q.pop_front(); total_cnt++;
    if (g1 !== e) $display("FAIL timeout_key: got %h expected %h", g1, e);
    else pass_cnt++;
    e = exp_q.pop_front(); total_cnt++;
    if (g2 !== e) $display("FAIL timeout_idle: got %h expected %h", g2, e);
    else pass_cnt++;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (timeout_clr === 1'b1) pulses++;
    end
`ifdef CALC_TIMEOUT_EN
    model_clear();
    total_cnt++;
    if (pulses !== 1) $display("FAIL timeout_pulse_count: got %0d expected 1", pulses);
    else pass_cnt++;
`else
    total_cnt++;
    if (pulses !== 0) $display("FAIL timeout_disabled_pulses: got %0d expected 0", pulses);
    else pass_cnt++;
`endif
    exp_q.push_back(model_vec(1'b0, 1'b0));
    e = exp_q.pop_front(); g = dut_vec(); total_cnt++;
    if (g !== e) $display("FAIL timeout_after_idle: got %h expected %h", g, e);
    else pass_cnt++;
    apply_reset();
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (timeout_clr === 1'b1) pulses++;
    end
    total_cnt++;
    if (pulses !== 0) $display("FAIL timeout_blank_a: got %0d expected 0", pulses);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [VW-1:0] e, g1, g2;
    logic [3:0] c;
    apply_reset();
    for (int i = 0; i < 80; i++) begin
      c = 4'($urandom_range(0, 15));
      press(c, g1, g2);
      e = exp_q.pop_front(); total_cnt++;
      if (g1 !== e) $display("FAIL rand_key%0d code %0d: got %h expected %h", i, c, g1, e);
      else pass_cnt++;
      e = exp_q.pop_front(); total_cnt++;
      if (g2 !== e) $display("FAIL rand_idle%0d: got %h expected %h", i, g2, e);
      else pass_cnt++;
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_basic_sequence();
    test_third_digit();
    test_held_key();
    test_op_replace_restart();
    test_clear_mid_b();
    test_async_reset();
    test_timeout();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/calc_entry_ctrl.md
# calc_entry_ctrl

Keypad-entry sequencer for the two-operand calculator. Turns a stream of key codes into the operand digit registers, operator select and display/math phase code that drive the digit mux and math datapath downstream. Owns the sequence: enter operand 1, pick operator, enter operand 2, show result, clear. Each key press is processed exactly once, however long the key is held.

## Interface
Parameters:
- TIMEOUT_CYCLES, 32'd500_000_000: idle cycles before auto-clear (used only with CALC_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- key_valid  in  1  level, high while a key is pressed; synchronous to clk.
- key_code  in  4  0–9 digit, 10 ADD, 11 SUB, 12 MUL, 13 DIV, 14 ENTER, 15 CLEAR; valid while key_valid high.
- num_state  out  3  phase code: 000 A_ENTRY, 001 OP_SEL, 010 B_ENTRY, 011 RESULT.
- tens_mem_1, ones_mem_1  out  5  operand A digits, values 0–9.
- tens_mem_2, ones_mem_2  out  5  operand B digits, values 0–9.
- arithmetic  out  5  one-hot operator: bit0 add, bit1 sub, bit2 mul, bit3 div, bit4 reserved 0. 00000 means none.
- key_err  out  1  one-cycle pulse when an accepted key edge is ignored by the current state.
- timeout_clr  out  1  one-cycle pulse on auto-clear.

## Operation
- **Edge detect:** key_d registers key_valid. A key event is key_valid & ~key_d. key_code is sampled at the event edge. A held key produces one event.
- **Digit shift, per operand:** tens ← ones, ones ← new digit, then count increments.
  - A third or later digit is ignored, with a key_err pulse.
  - A count of 0 or 1 leaves tens = 0.
- **CLEAR (any state):** sets A and B digits to 0, both counts to 0, arithmetic to 00000, and moves to A_ENTRY. No key_err.
- **A_ENTRY:**
  - digit: shift into A.
  - operator: latch one-hot op, go to OP_SEL. An A count of 0 is allowed and A stays 00.
  - ENTER: key_err.
- **OP_SEL:**
  - operator: replace op, stay in OP_SEL.
  - digit: B ← 0 then shifted digit, B count = 1, go to B_ENTRY.
  - ENTER: key_err.
- **B_ENTRY:**
  - digit: shift into B.
  - ENTER: go to RESULT.
  - operator: key_err, op unchanged.
- **RESULT:** A, B and op hold.
  - digit: clear everything, load the digit into A (count 1), go to A_ENTRY.
  - operator or ENTER: key_err.
- num_state encodings 100–111 are never produced. An illegal state register recovers to A_ENTRY with cleared registers on the next clock.

## Timing
- **Reset values (async, rst_n low):** num_state 000; all digit outputs 0; arithmetic 00000; key_err 0; timeout_clr 0; key_d 0; counts 0; timeout counter 0.
- **Latency:** 1 clock. The outputs change on the same rising edge at which the event (key_valid = 1, key_d = 0) is sampled.
- key_err and timeout_clr are high for exactly the one cycle after that edge.
- **Key held across reset release:** key_d = 0 after reset, so the first clock with rst_n high and key_valid high is an event. This is intended.
- **Reset mid-entry:** all state is lost immediately; no pending event survives.
- **Minimum key spacing:** key_valid must be low for at least 1 clock between presses. Otherwise the second press is invisible.

## Configuration
- **CALC_TIMEOUT_EN defined:** a 32-bit idle counter increments every clock and resets to 0 on every key event.
  - When the counter reaches TIMEOUT_CYCLES−1 and state ≠ A_ENTRY-with-count-0, perform CLEAR and pulse timeout_clr for 1 cycle.
  - A key event in the same cycle as the expiry wins. The key is processed and the counter resets.
- **CALC_TIMEOUT_EN undefined:** there is no counter, timeout_clr is tied 0, and registers hold indefinitely.

## Test plan
- Reset, then keys 4, 7, ADD, 1, 2, ENTER → A = 4/7, arithmetic 00001, B = 1/2, num_state 011; key_err never pulses.
- Keys 1, 2, 3 in A_ENTRY → third press pulses key_err; tens_mem_1 = 1, ones_mem_1 = 2.
- key_valid held high 20 cycles with code 5 → exactly one shift, ones_mem_1 = 5.
- A = 9, MUL, then SUB in OP_SEL → arithmetic 00010. Then 3, ENTER, then digit 6 in RESULT → num_state 000, A = 0/6, B = 0/0, arithmetic 00000.
- Mid-B-entry CLEAR → all zeros, num_state 000. Separately, assert rst_n low asynchronously between clock edges → outputs go to reset values immediately.
- With CALC_TIMEOUT_EN and TIMEOUT_CYCLES = 16: enter 3, idle 16 cycles → timeout_clr pulses once and everything is cleared. Then, with A count 0, idle 40 cycles → no pulse.
